framebuf_ctrl: RTL and testbench

Write-port controller for the shared 512×8 framebuffer BRAM. Arbitrates two write requesters (timer renderer, effects engine) onto the single RAM write port with round-robin fairness. Contains a built-in clear engine that sequentially fills the buffer with a constant. Sits in the same clock domain as the write side of the framebuffer; the neopixel read port is untouched.

---
 rtl/framebuf_ctrl_if.sv | 29 ++
 rtl/framebuf_ctrl.sv | 151 +++++++++++++++
 tb/tb_framebuf_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/framebuf_ctrl_if.sv
// Write-side bus of the framebuffer controller: two write requesters, clear control and the RAM write port.
interface framebuf_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              ack0;
    logic              ack1;
    logic              clear_req;
    logic              clear_busy;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_din;

    modport master (
        output req0, req1, addr0, addr1, data0, data1, clear_req,
        input  ack0, ack1, clear_busy, ram_we, ram_waddr, ram_din
    );

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1, clear_req,
        output ack0, ack1, clear_busy, ram_we, ram_waddr, ram_din
    );
endinterface

// File: rtl/framebuf_ctrl.sv
// Round-robin write-port arbiter for the 512x8 framebuffer BRAM, with a sequential clear engine
// that is only built when FBCTRL_CLEAR_EN is defined.
module framebuf_ctrl #(
    parameter int                ADDR_W      = 9,
    parameter int                DATA_W      = 8,
    parameter int                CLEAR_DEPTH = 512,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
    input  logic           CLK,
    input  logic           RST_N,
    framebuf_ctrl_if.slave bus
);

`ifdef FBCTRL_CLEAR_EN
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(CLEAR_DEPTH - 1);
`else
    typedef enum logic {IDLE, WRITE} state_t;
`endif

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              grant1;

`ifdef FBCTRL_CLEAR_EN
    logic              busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   cntNext;

    assign cntNext = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
`else
    logic              unusedClear;

    assign unusedClear = ^{bus.clear_req, CLEAR_VALUE, CLEAR_DEPTH[0]};
`endif

    // Requester 1 wins when it is alone, or when both contend and the pointer favours it.
    assign grant1 = bus.req1 && (!bus.req0 || ptr_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        din_d   = din_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
`ifdef FBCTRL_CLEAR_EN
        busy_d  = 1'b0;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef FBCTRL_CLEAR_EN
                if (bus.clear_req) begin
                    state_d = CLEAR;
                    we_d    = 1'b1;
                    waddr_d = '0;
                    din_d   = CLEAR_VALUE;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else
`endif
                if (bus.req0 || bus.req1) begin
                    state_d = WRITE;
                    we_d    = 1'b1;
                    if (grant1) begin
                        ack1_d  = 1'b1;
                        waddr_d = bus.addr1;
                        din_d   = bus.data1;
                        ptr_d   = 1'b0;
                    end else begin
                        ack0_d  = 1'b1;
                        waddr_d = bus.addr0;
                        din_d   = bus.data0;
                        ptr_d   = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
`ifdef FBCTRL_CLEAR_EN
            // The counter holds the address currently on the RAM port; it restarts at zero on exit.
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = cntNext;
                    waddr_d = cntNext[ADDR_W-1:0];
                    din_d   = CLEAR_VALUE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

`ifdef FBCTRL_CLEAR_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.clear_busy = busy_q;
`else
    assign bus.clear_busy = 1'b0;
`endif

    assign bus.ram_we    = we_q;
    assign bus.ram_waddr = waddr_q;
    assign bus.ram_din   = din_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;

endmodule

// File: tb/tb_framebuf_ctrl.sv
// Randomized bench for framebuf_ctrl against a transaction-level model of arbitration, clear and reset.
module tb_framebuf_ctrl;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 512;
`ifdef FBCTRL_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    framebuf_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fb ();

    framebuf_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .CLEAR_DEPTH(DEPTH),
        .CLEAR_VALUE(8'h00)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (fb.slave)
    );

    always #5 CLK = ~CLK;

    int testsRun;
    int testsFailed;
    int obsBusyWrites;
    int ackSeen0;
    int ackSeen1;
    int obsWrites;
    int memBad;

    logic              mWe;
    logic [ADDR_W-1:0] mAddr;
    logic [DATA_W-1:0] mDin;
    logic              mAck0;
    logic              mAck1;
    logic              mBusy;
    int                clearLeft;
    bit                inWrite;
    int                prefer;

    logic [DATA_W-1:0] expMem [DEPTH];
    logic [DATA_W-1:0] dutMem [DEPTH];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void modelReset();
        mWe       = 1'b0;
        mAddr     = '0;
        mDin      = '0;
        mAck0     = 1'b0;
        mAck1     = 1'b0;
        mBusy     = 1'b0;
        clearLeft = 0;
        inWrite   = 1'b0;
        prefer    = 0;
    endfunction

    // One rising edge: a clear occupies DEPTH write edges plus one exit edge, a grant occupies two edges.
    function automatic void modelStep();
        int winner;
        mAck0 = 1'b0;
        mAck1 = 1'b0;
        mWe   = 1'b0;
        if (clearLeft > 0) begin
            clearLeft--;
            mBusy = (clearLeft > 0);
            if (clearLeft > 0) begin
                mWe   = 1'b1;
                mAddr = ADDR_W'(DEPTH - clearLeft);
                mDin  = 8'h00;
            end
        end else if (inWrite) begin
            inWrite = 1'b0;
        end else if (CLR_EN && fb.clear_req) begin
            clearLeft = DEPTH;
            mBusy     = 1'b1;
            mWe       = 1'b1;
            mAddr     = '0;
            mDin      = 8'h00;
        end else if (fb.req0 || fb.req1) begin
            if (fb.req0 && fb.req1) winner = prefer;
            else winner = fb.req1 ? 1 : 0;
            prefer  = 1 - winner;
            inWrite = 1'b1;
            mWe     = 1'b1;
            if (winner == 0) begin
                mAck0 = 1'b1;
                mAddr = fb.addr0;
                mDin  = fb.data0;
            end else begin
                mAck1 = 1'b1;
                mAddr = fb.addr1;
                mDin  = fb.data1;
            end
        end
        if (mWe) expMem[mAddr] = mDin;
    endfunction

    task automatic tickCycle();
        @(posedge CLK);
        if (!RST_N) modelReset();
        else modelStep();
        @(negedge CLK);
        if (fb.ram_we === 1'b1) dutMem[fb.ram_waddr] = fb.ram_din;
        if (fb.ram_we === 1'b1 && fb.clear_busy === 1'b1) obsBusyWrites++;
        checkOutput("ram_we", 32'(fb.ram_we), 32'(mWe));
        checkOutput("ram_waddr", 32'(fb.ram_waddr), 32'(mAddr));
        checkOutput("ram_din", 32'(fb.ram_din), 32'(mDin));
        checkOutput("ack0", 32'(fb.ack0), 32'(mAck0));
        checkOutput("ack1", 32'(fb.ack1), 32'(mAck1));
        checkOutput("clear_busy", 32'(fb.clear_busy), 32'(mBusy));
    endtask

    task automatic driveIdle();
        fb.req0      = 1'b0;
        fb.req1      = 1'b0;
        fb.addr0     = '0;
        fb.addr1     = '0;
        fb.data0     = '0;
        fb.data1     = '0;
        fb.clear_req = 1'b0;
    endtask

    // Requesters drop or replace a transaction only in the cycle the model says it was acked.
    task automatic applyStimulus(input int newPct);
        if (mAck0 || !fb.req0) begin
            if (int'($urandom_range(99)) < newPct) begin
                fb.req0  = 1'b1;
                fb.addr0 = ADDR_W'($urandom);
                fb.data0 = DATA_W'($urandom);
            end else begin
                fb.req0 = 1'b0;
            end
        end
        if (mAck1 || !fb.req1) begin
            if (int'($urandom_range(99)) < newPct) begin
                fb.req1  = 1'b1;
                fb.addr1 = ADDR_W'($urandom);
                fb.data1 = DATA_W'($urandom);
            end else begin
                fb.req1 = 1'b0;
            end
        end
    endtask

    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        obsBusyWrites = 0;
        for (int a = 0; a < DEPTH; a++) begin
            expMem[a] = '0;
            dutMem[a] = '0;
        end
        driveIdle();
        modelReset();

        repeat (3) tickCycle();

        RST_N    = 1'b1;
        fb.req0  = 1'b1;
        fb.addr0 = 9'h005;
        fb.data0 = 8'hA5;
        tickCycle();
        checkOutput("single_ack0", 32'(fb.ack0), 32'd1);
        checkOutput("single_ack1", 32'(fb.ack1), 32'd0);
        checkOutput("single_addr", 32'(fb.ram_waddr), 32'h005);
        checkOutput("single_din", 32'(fb.ram_din), 32'hA5);
        fb.req0 = 1'b0;
        repeat (4) tickCycle();

        RST_N    = 1'b0;
        fb.req0  = 1'b1;
        fb.addr0 = 9'h0A0;
        fb.data0 = 8'h11;
        fb.req1  = 1'b1;
        fb.addr1 = 9'h1B1;
        fb.data1 = 8'h22;
        tickCycle();
        RST_N = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tickCycle();
            checkOutput("alt_ack0", 32'(fb.ack0), 32'((c % 4) == 0));
            checkOutput("alt_ack1", 32'(fb.ack1), 32'((c % 4) == 2));
        end

        driveIdle();
        tickCycle();
        for (int c = 0; c < 800; c++) begin
            applyStimulus(40);
            fb.clear_req = ($urandom_range(199) == 0);
            tickCycle();
        end
        fb.clear_req = 1'b0;
        repeat (600) begin
            applyStimulus(0);
            tickCycle();
        end

        obsBusyWrites = 0;
        ackSeen0      = 0;
        ackSeen1      = 0;
        fb.req0       = 1'b1;
        fb.addr0      = 9'h033;
        fb.data0      = 8'h5C;
        fb.clear_req  = 1'b1;
        tickCycle();
        if (fb.ack0 === 1'b1) ackSeen0++;
        for (int c = 1; c < 530; c++) begin
            applyStimulus(0);
            fb.clear_req = (c == 200);
            if (c == 10) begin
                fb.req1  = 1'b1;
                fb.addr1 = 9'h1F0;
                fb.data1 = 8'hC3;
            end
            tickCycle();
            if (fb.ack0 === 1'b1) ackSeen0++;
            if (fb.ack1 === 1'b1) ackSeen1++;
        end
        fb.clear_req = 1'b0;
        checkOutput("clear_write_count", 32'(obsBusyWrites), CLR_EN ? 32'd512 : 32'd0);
        checkOutput("held_ack0_count", 32'(ackSeen0), 32'd1);
        checkOutput("held_ack1_count", 32'(ackSeen1), 32'd1);

        driveIdle();
        repeat (3) tickCycle();
        fb.clear_req = 1'b1;
        tickCycle();
        fb.clear_req = 1'b0;
        repeat (100) tickCycle();
        #2 RST_N = 1'b0;
        #1;
        checkOutput("rst_clear_we", 32'(fb.ram_we), 32'd0);
        checkOutput("rst_clear_addr", 32'(fb.ram_waddr), 32'd0);
        checkOutput("rst_clear_din", 32'(fb.ram_din), 32'd0);
        checkOutput("rst_clear_busy", 32'(fb.clear_busy), 32'd0);
        modelReset();
        repeat (2) tickCycle();
        RST_N     = 1'b1;
        obsWrites = 0;
        repeat (20) begin
            tickCycle();
            if (fb.ram_we === 1'b1) obsWrites++;
        end
        checkOutput("no_write_after_rst", 32'(obsWrites), 32'd0);

        fb.req1  = 1'b1;
        fb.addr1 = 9'h077;
        fb.data1 = 8'h3E;
        tickCycle();
        checkOutput("pre_rst_ack1", 32'(fb.ack1), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        checkOutput("rst_ack_ack1", 32'(fb.ack1), 32'd0);
        checkOutput("rst_ack_we", 32'(fb.ram_we), 32'd0);
        checkOutput("rst_ack_addr", 32'(fb.ram_waddr), 32'd0);
        modelReset();
        fb.req1 = 1'b0;
        tickCycle();
        RST_N = 1'b1;
        repeat (5) tickCycle();

        memBad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (dutMem[a] !== expMem[a]) memBad++;
        end
        checkOutput("mem_image", 32'(memBad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
